vga_timing: RTL

//  Raster timing generator for the I/O system VGA path. Runs on the VGA clock

---
 rtl/vga_timing_if.sv | 40 ++++
 rtl/vga_timing.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing_if
//  Purpose  : Raster timing bundle from the VGA timing generator to the
//             character/pixel renderer.
//  Signals  : pixel_en     - one-clk strobe, coordinates advance on it
//             pixel_x/y    - current column / row (10 bits each)
//             hsync/vsync  - active-low sync pulses
//             blank        - outside the visible area
//             last_column  - pixel_x is the final column of the line
//             last_row     - pixel_y is the final row of the frame
//             new_frame    - pulse on the final pixel_en of a frame
//             frame_count  - completed-frame counter (16 bits)
//  Modports : master (timing generator), slave (renderer)
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_if;
    logic        pixel_en;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        last_column;
    logic        last_row;
    logic        new_frame;
    logic [15:0] frame_count;

    modport master (
        output pixel_en, pixel_x, pixel_y, hsync, vsync, blank,
               last_column, last_row, new_frame, frame_count
    );

    modport slave (
        input  pixel_en, pixel_x, pixel_y, hsync, vsync, blank,
               last_column, last_row, new_frame, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : 640x480@60 Hz raster timing generator. Divides the VGA clock
//             down to a pixel-enable strobe and produces pixel coordinates,
//             active-low sync, blanking and frame markers.
//  Ports    : clk  - VGA clock
//             rst  - synchronous, active-high reset
//             vga  - vga_timing_if.master timing bundle
//  Config   : define VGA_TIMING_FRAME_COUNT_EN to build the completed-frame
//             counter; otherwise frame_count is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int PIXEL_CLK_DIVIDE = 2,
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT_PORCH    = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK_PORCH     = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT_PORCH    = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK_PORCH     = 33
) (
    input  wire logic    clk,
    input  wire logic    rst,
    vga_timing_if.master vga
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int c_DIV_W   = (PIXEL_CLK_DIVIDE > 1) ? $clog2(PIXEL_CLK_DIVIDE) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIXEL_CLK_DIVIDE - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [9:0]         c_X_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]         c_Y_LAST   = 10'(c_V_TOTAL - 1);

    // Decode bounds are one bit wider than the counters so a sync pulse that
    // ends exactly at a 1024 total still compares correctly.
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_HS_START   = 11'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [10:0] c_HS_END     = 11'(H_VISIBLE + H_FRONT_PORCH + H_SYNC);
    localparam logic [10:0] c_VS_START   = 11'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [10:0] c_VS_END     = 11'(V_VISIBLE + V_FRONT_PORCH + V_SYNC);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [9:0]         r_pixel_x;
    logic [9:0]         r_pixel_y;

    logic        w_pixel_en;
    logic        w_last_column;
    logic        w_last_row;
    logic        w_new_frame;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;

    assign w_x_ext       = {1'b0, r_pixel_x};
    assign w_y_ext       = {1'b0, r_pixel_y};
    // With a divide of one the counter is stuck at zero, which equals
    // c_DIV_LAST, so the strobe is permanently high.
    assign w_pixel_en    = (r_div_cnt == c_DIV_LAST);
    assign w_last_column = (r_pixel_x == c_X_LAST);
    assign w_last_row    = (r_pixel_y == c_Y_LAST);
    assign w_new_frame   = w_pixel_en & w_last_column & w_last_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_pixel_x <= '0;
            r_pixel_y <= '0;
        end else begin
            if (w_pixel_en) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end

            if (w_pixel_en) begin
                if (w_last_column) begin
                    r_pixel_x <= '0;
                    if (w_last_row) begin
                        r_pixel_y <= '0;
                    end else begin
                        r_pixel_y <= r_pixel_y + 10'd1;
                    end
                end else begin
                    r_pixel_x <= r_pixel_x + 10'd1;
                end
            end
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Counts only frames that reach their final pixel; a reset mid-frame
    // clears the count and the partial frame is never credited.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_new_frame) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign vga.frame_count = r_frame_count;
`else
    assign vga.frame_count = 16'h0000;
`endif

    // Decodes are combinational so they line up with the coordinates in the
    // same cycle; downstream pipelines add their own matching delay.
    assign vga.pixel_en    = w_pixel_en;
    assign vga.pixel_x     = r_pixel_x;
    assign vga.pixel_y     = r_pixel_y;
    assign vga.hsync       = ~((w_x_ext >= c_HS_START) && (w_x_ext < c_HS_END));
    assign vga.vsync       = ~((w_y_ext >= c_VS_START) && (w_y_ext < c_VS_END));
    assign vga.blank       = (w_x_ext >= c_H_VIS) || (w_y_ext >= c_V_VIS);
    assign vga.last_column = w_last_column;
    assign vga.last_row    = w_last_row;
    assign vga.new_frame   = w_new_frame;

endmodule
`default_nettype wire
